// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise, debounce and edge-detect active-low pushbuttons
//
// Per channel: two-flop synchroniser, a debounce counter that accepts a new
// level after DEBOUNCE_CYCLES consecutive differing synchronised samples, and
// one-cycle press/release pulses on the accepting edge.
//
// Optional auto-repeat on channels selected by REPEAT_MASK is built only when
// the macro BUTTON_AUTOREPEAT_EN is defined.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   btn_raw_n    raw button pins, active-low, asynchronous to clk
//   btn_n        debounced level, active-low, registered
//   btn_press    one-cycle pulse per accepted press (plus repeats when enabled)
//   btn_release  one-cycle pulse per accepted release
module button_conditioner #(
  parameter int                 NUM_BTN         = 4,
  parameter int                 DEBOUNCE_CYCLES = 250000,
  parameter int                 CNT_W           = 18,
  parameter int                 REPEAT_DELAY    = 12500000,
  parameter int                 REPEAT_PERIOD   = 2500000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_raw_n,
  output logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] sync_s1;
  logic [NUM_BTN-1:0] sync_s2;
  logic [CNT_W-1:0]   cnt [NUM_BTN];
  logic [NUM_BTN-1:0] accept;
  logic [NUM_BTN-1:0] accept_press;
  logic [NUM_BTN-1:0] accept_release;
  logic [NUM_BTN-1:0] repeat_pulse;

  // A channel accepts on the edge that would see its D-th consecutive
  // differing sample; the counter never passes CNT_LAST.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      accept[i] = (sync_s2[i] != btn_n[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // When accepting, sync_s2 holds the new level: 0 means a press.
  assign accept_press   = accept & ~sync_s2;
  assign accept_release = accept &  sync_s2;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0]   rep_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] rep_armed;   // first repeat already issued: use PERIOD
  logic [NUM_BTN-1:0] rep_fire;

  // Repeats only while held and never on the edge that accepts the release.
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      rep_fire[i] = REPEAT_MASK[i] && !btn_n[i] && !accept_release[i] &&
                    (rep_cnt[i] == (rep_armed[i] ? PERIOD_LAST : DELAY_LAST));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_armed <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        rep_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (!REPEAT_MASK[i] || accept_press[i] || btn_n[i] || accept_release[i]) begin
          rep_cnt[i]   <= '0;
          rep_armed[i] <= 1'b0;
        end else if (rep_fire[i]) begin
          rep_cnt[i]   <= '0;
          rep_armed[i] <= 1'b1;
        end else begin
          rep_cnt[i]   <= rep_cnt[i] + REP_W'(1);
        end
      end
    end
  end

  assign repeat_pulse = rep_fire;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_MASK, REPEAT_DELAY, REPEAT_PERIOD};
  assign repeat_pulse      = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_s1     <= '1;
      sync_s2     <= '1;
      btn_n       <= '1;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync_s1     <= btn_raw_n;
      sync_s2     <= sync_s1;
      btn_n       <= btn_n ^ accept;
      btn_press   <= accept_press | repeat_pulse;
      btn_release <= accept_release;
      for (int i = 0; i < NUM_BTN; i++) begin
        // Any sample matching the stable level restarts the count.
        if ((sync_s2[i] == btn_n[i]) || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner
`timescale 1ns/1ps
module tb_button_conditioner;

  localparam int         NB = 4;
  localparam int         DB = 4;
  localparam int         RD = 20;
  localparam int         RP = 8;
  localparam logic [3:0] RM = 4'b0001;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] btn_raw_n = 4'hF;
  logic [3:0] btn_n;
  logic [3:0] btn_press;
  logic [3:0] btn_release;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .CNT_W(3),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_MASK(RM)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_raw_n(btn_raw_n),
    .btn_n(btn_n), .btn_press(btn_press), .btn_release(btn_release)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    int cyc;
    int ch;
    bit press;
  } ev_t;

  ev_t        exp_q[$];
  logic [3:0] hist[$];          // raw samples per edge, oldest first
  logic [3:0] mdl_lvl = 4'hF;   // accepted level per channel
  logic [3:0] nxt_lvl;
  logic [3:0] rep_mask = RM;
  int         acc_cyc[NB];
  int         cyc = 0;
  int         run;
  int         n;
  ev_t        ev;

  // Reference model: a level is accepted once DB consecutive synchronised
  // samples (raw delayed two edges) differ from the current level.
  always @(posedge clk) begin
    cyc++;
    if (!reset_n || hist.size() < 2) begin
      hist.delete();
      hist.push_back(4'hF);
      hist.push_back(4'hF);
      mdl_lvl = 4'hF;
    end else begin
      nxt_lvl = mdl_lvl;
      for (int ch = 0; ch < NB; ch++) begin
        run = 0;
        for (int k = hist.size() - 2; k >= 0 && run < DB; k--) begin
          if (hist[k][ch] != mdl_lvl[ch]) run++;
          else break;
        end
        if (run >= DB) begin
          ev.cyc = cyc; ev.ch = ch; ev.press = mdl_lvl[ch];
          exp_q.push_back(ev);
          if (mdl_lvl[ch]) acc_cyc[ch] = cyc;
          nxt_lvl[ch] = ~mdl_lvl[ch];
        end else if (REP_ON && rep_mask[ch] && !mdl_lvl[ch]) begin
          n = cyc - acc_cyc[ch];
          if (n == RD || (n > RD && (n - RD) % RP == 0)) begin
            ev.cyc = cyc; ev.ch = ch; ev.press = 1'b1;
            exp_q.push_back(ev);
          end
        end
      end
      mdl_lvl = nxt_lvl;
      hist.push_back(btn_raw_n);
      if (hist.size() > 16) void'(hist.pop_front());
    end
  end

  ev_t mev;

  task automatic match(input int ch, input bit press);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse ch %0d press %0d at cycle %0d, none expected", ch, press, cyc);
    end else begin
      mev = exp_q.pop_front();
      chk("event_cycle", cyc, mev.cyc);
      chk("event_channel", ch, mev.ch);
      chk("event_kind", int'(press), int'(mev.press));
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard away from the edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) void'(exp_q.pop_front());
      chk("reset_level", int'(btn_n), 'hF);
      chk("reset_pulses", int'({btn_press, btn_release}), 0);
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mev = exp_q.pop_front();
        chk("missed_event_cycle", cyc, mev.cyc);
      end
      chk("level", int'(btn_n), int'(mdl_lvl));
      chk("press_release_overlap", int'(btn_press & btn_release), 0);
      for (int ch = 0; ch < NB; ch++) begin
        if (btn_press[ch])   match(ch, 1'b1);
        if (btn_release[ch]) match(ch, 1'b0);
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #3;
  endtask

  int cnt0;
  int cnt1;
  int hold[NB];

  initial begin
    #1 reset_n = 1'b0;
    btn_raw_n = 4'b0101;
    step(3);
    chk("dir_reset_btn_n", int'(btn_n), 'hF);
    chk("dir_reset_press", int'(btn_press), 0);
    chk("dir_reset_release", int'(btn_release), 0);
    btn_raw_n = 4'hF;
    step(1);
    reset_n = 1'b1;
    step(8);

    // Clean press on channel 1
    btn_raw_n[1] = 1'b0;
    step(5);
    chk("clean_before_btn_n", int'(btn_n), 'hF);
    chk("clean_before_press", int'(btn_press), 0);
    step(1);
    chk("clean_btn_n", int'(btn_n), 'b1101);
    chk("clean_press", int'(btn_press), 'b0010);
    step(1);
    chk("clean_press_one_cycle", int'(btn_press), 0);
    btn_raw_n[1] = 1'b1;
    step(6);
    chk("clean_release", int'(btn_release), 'b0010);
    step(3);

    // Bounce on channel 2
    btn_raw_n[2] = 1'b0;
    step(3);
    btn_raw_n[2] = 1'b1;
    step(1);
    btn_raw_n[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("bounce_hold_btn_n", int'(btn_n[2]), 1);
      chk("bounce_hold_press", int'(btn_press), 0);
    end
    step(1);
    chk("bounce_btn_n", int'(btn_n), 'b1011);
    chk("bounce_press", int'(btn_press), 'b0100);
    btn_raw_n[2] = 1'b1;
    step(10);

    // Simultaneous release on channels 0 and 3
    btn_raw_n[0] = 1'b0;
    btn_raw_n[3] = 1'b0;
    step(10);
    btn_raw_n[0] = 1'b1;
    btn_raw_n[3] = 1'b1;
    step(5);
    chk("simul_before_btn_n", int'(btn_n), 'b0110);
    step(1);
    chk("simul_release", int'(btn_release), 'b1001);
    chk("simul_btn_n", int'(btn_n), 'hF);
    step(3);

    // Reset in the middle of debouncing a press on channel 1
    btn_raw_n[1] = 1'b0;
    step(2);
    reset_n = 1'b0;
    #1;
    chk("midreset_btn_n", int'(btn_n), 'hF);
    chk("midreset_pulses", int'({btn_press, btn_release}), 0);
    step(1);
    reset_n = 1'b1;
    step(5);
    chk("midreset_before_btn_n", int'(btn_n), 'hF);
    step(1);
    chk("midreset_btn_n_after", int'(btn_n), 'b1101);
    chk("midreset_press", int'(btn_press), 'b0010);
    btn_raw_n[1] = 1'b1;
    step(10);

    // Long hold on channels 0 (repeat-enabled) and 1
    btn_raw_n[0] = 1'b0;
    btn_raw_n[1] = 1'b0;
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 55; i++) begin
      step(1);
      cnt0 += int'(btn_press[0]);
      cnt1 += int'(btn_press[1]);
    end
    chk("hold_ch0_press_count", cnt0, REP_ON ? 5 : 1);
    chk("hold_ch1_press_count", cnt1, 1);
    btn_raw_n = 4'hF;
    step(10);

    // Randomised bouncing and holds, with occasional resets
    for (int ch = 0; ch < NB; ch++) hold[ch] = $urandom_range(1, 6);
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < NB; ch++) begin
        if (hold[ch] == 0) begin
          btn_raw_n[ch] = ~btn_raw_n[ch];
          hold[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 6);
        end else begin
          hold[ch]--;
        end
      end
      if (c % 1000 == 999) begin
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
      end
      step(1);
    end

    btn_raw_n = 4'hF;
    step(20);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-conditioning stage directly upstream of the raybox_zero game core on the board wrapper.
- Takes raw, bouncy, asynchronous active-low pushbutton signals from the onboard KEY pins and the external K-button board. Produces synchronised, debounced, active-low levels that drive new_game_n, pause_n, up_key_n and down_key_n.
- Also produces one-cycle press and release pulses.
- Replaces the bare two-flop synchronisers in the wrapper with a single parameterised block.

Parameters:
- NUM_BTN, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 250000, consecutive stable synchronised samples required to accept a level change (10 ms at 25 MHz); must be >= 1.
- CNT_W, 18, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- REPEAT_DELAY, 12500000, hold cycles from the accepted press to the first auto-repeat pulse (used only with the optional feature).
- REPEAT_PERIOD, 2500000, cycles between subsequent auto-repeat pulses (used only with the optional feature).
- REPEAT_MASK, 4'b0000, per-channel auto-repeat enable bits (used only with the optional feature).

Ports:
- clk, input, 1, system clock (the 25 MHz pixel clock in the wrapper).
- reset_n, input, 1, asynchronous active-low reset.
- btn_raw_n, input, NUM_BTN, raw button pins, active-low (0 = pressed), asynchronous to clk.
- btn_n, output, NUM_BTN, debounced level, active-low, registered.
- btn_press, output, NUM_BTN, one-cycle pulse per accepted press, registered.
- btn_release, output, NUM_BTN, one-cycle pulse per accepted release, registered.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (reset_n). Every flop clears asynchronously on reset_n low.
- Reset values:
  - sync stages all 1;
  - btn_n all 1 (released);
  - btn_press and btn_release all 0;
  - debounce and repeat counters 0.
- Per channel, all channels fully independent:
  - Sync stage: two-flop synchroniser, s1 <= raw, s2 <= s1.
  - Debounce compare: s2 against the stable state btn_n[i].
    - s2 == btn_n[i]: counter clears to 0.
    - s2 != btn_n[i] and counter < DEBOUNCE_CYCLES-1: counter increments.
    - s2 != btn_n[i] and counter == DEBOUNCE_CYCLES-1: at that edge btn_n[i] takes s2 and the counter clears.
  - Pulse on accept: on the same edge btn_n[i] goes 1->0, btn_press[i] is set for exactly one cycle. On a 0->1 change, btn_release[i] is set for exactly one cycle.
- Latency: the raw level is first sampled by s1 at edge 1 and must then be held. btn_n changes at edge DEBOUNCE_CYCLES+2, and the pulse is visible in that same cycle.
- Bounce: any single sample of s2 equal to btn_n[i] restarts the count. A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes btn_n and never pulses.
- Counter width: the counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.
- Simultaneous events: several channels may accept changes on the same edge, and their pulses coincide. btn_press and btn_release are never both 1 on the same channel.
- Reset mid-debounce: all progress is discarded.
- Button held through reset release: after reset_n deasserts, the block treats the button as a fresh press. btn_n falls DEBOUNCE_CYCLES+2 edges later with exactly one btn_press pulse.

Optional Feature:
- Macro: BUTTON_AUTOREPEAT_EN.
- Defined: each channel with REPEAT_MASK[i]=1 has a repeat counter.
  - The counter loads 0 on the accepted press and increments while btn_n[i]==0.
  - First extra btn_press[i] pulse REPEAT_DELAY cycles after the accepted-press edge.
  - After that, one pulse every REPEAT_PERIOD cycles while the button is held.
  - Release, or reset, stops repeating immediately; a repeat pulse never coincides with btn_release.
- Undefined: no repeat logic is synthesised. REPEAT_DELAY, REPEAT_PERIOD and REPEAT_MASK are ignored, and there is exactly one btn_press per accepted press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, REPEAT_MASK=4'b0001 unless stated):
- Reset:
  - Stimulus: reset_n low with arbitrary btn_raw_n.
  - Required: btn_n=4'b1111, btn_press=btn_release=0, held for as long as reset_n is low.
- Clean press:
  - Stimulus: btn_raw_n[1] 1->0 and held, edge 1 first samples it.
  - Required: btn_n[1]=0 and btn_press[1]=1 at edge 6 only; no other channel moves.
- Bounce rejection:
  - Stimulus: btn_raw_n[2] low for 3 cycles, high for 1, then low and held.
  - Required: no change during the glitch; btn_n[2] falls 6 edges after the final low is first sampled, with a single press pulse.
- Release plus simultaneity:
  - Stimulus: channels 0 and 3 held pressed, both raw released on the same edge.
  - Required: btn_release[0] and btn_release[3] pulse together on edge 6 and btn_n returns to 1 on both.
- Reset mid-debounce:
  - Stimulus: pulse reset_n low 2 cycles into a press while raw is held.
  - Required: outputs cleared, then press accepted 6 edges after reset release.
- Auto-repeat (macro defined):
  - Stimulus: hold channel 0 for 50 cycles.
  - Required: btn_press[0] pulses at accept, accept+20, +28, +36, +44; channel 1 held the same way gives one pulse only.
  - Same hold with the macro undefined: one pulse only.
